// File: rtl/lal_seq_ctrl.sv
// lal_seq_ctrl: load/run/done sequencer around a saturating up-counter with a registered compare flag.
// Build option: define LAL_SEQ_CTRL_MATCH_STOP_EN to also end a run when cmp_a == cmp_b.
// Ports:
//   clk      - sole clock, rising edge
//   rst_n    - synchronous active-low reset
//   start    - run request, sampled only in IDLE
//   load_val - counter start value, taken on the LOAD edge
//   hold     - pauses counting and state in RUN
//   cmp_a/b  - compare operands
//   count    - counter register
//   busy     - high whenever not IDLE
//   tc       - count is all-ones
//   match    - registered cmp_a == cmp_b
//   done     - one-cycle completion pulse
module lal_seq_ctrl #(
  parameter int W  = 9,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  load_val,
  input  logic          hold,
  input  logic [CW-1:0] cmp_a,
  input  logic [CW-1:0] cmp_b,
  output logic [W-1:0]  count,
  output logic          busy,
  output logic          tc,
  output logic          match,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] count_nx;
  logic match_nx, eq, stop;
  assign eq   = cmp_a == cmp_b;
  assign tc   = &count;
  assign busy = state != IDLE;
  assign done = state == DONE;
`ifdef LAL_SEQ_CTRL_MATCH_STOP_EN
  assign stop = tc | eq;
`else
  assign stop = tc;
`endif
  always_comb begin
    state_nx = state;
    count_nx = count;
    match_nx = match;
    case (state)
      IDLE: state_nx = start ? LOAD : IDLE;
      LOAD: begin
        count_nx = load_val;
        match_nx = 1'b0;
        state_nx = RUN;
      end
      RUN: begin
        match_nx = eq;
        // a finishing edge leaves count where it is, so the counter saturates
        if (!hold) begin
          state_nx = stop ? DONE : RUN;
          count_nx = stop ? count : count + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      match <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      match <= match_nx;
    end
  end
endmodule

// File: tb/tb_lal_seq_ctrl.sv
// tb_lal_seq_ctrl: directed bench with a done-pulse scoreboard for lal_seq_ctrl.
module tb_lal_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n, start, hold;
  logic [8:0] load_val, count;
  logic [3:0] cmp_a, cmp_b;
  logic busy, tc, match, done;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [8:0] count;
    logic match;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  lal_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_val(load_val), .hold(hold),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .count(count), .busy(busy), .tc(tc),
    .match(match), .done(done)
  );
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done count=%0h match=%0b", count, match);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (count !== e.count || match !== e.match || tc !== (&e.count)) begin
          failures++;
          $display("FAIL sb_done got count=%0h match=%0b tc=%0b exp count=%0h match=%0b tc=%0b",
                   count, match, tc, e.count, e.match, &e.count);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [8:0] c, input logic m);
    exp_t e;
    e.count = c;
    e.match = m;
    sb.push_back(e);
  endtask
  task automatic wait_done(input int max, input string name);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; load_val = '0; cmp_a = 4'd1; cmp_b = 4'd2;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tc", tc, 0);
    chk("rst_match", match, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", busy, 0);
    // basic run to terminal count
    push(9'h1FF, 1'b0);
    start = 1'b1; load_val = 9'h1FC;
    tick();
    start = 1'b0;
    chk("a_load_busy", busy, 1);
    tick(); chk("a_c0", count, 9'h1FC);
    tick(); chk("a_c1", count, 9'h1FD);
    tick(); chk("a_c2", count, 9'h1FE);
    tick(); chk("a_c3", count, 9'h1FF);
    chk("a_tc_run", {done, tc}, 2'b01);
    tick(); chk("a_done", {done, count}, {1'b1, 9'h1FF});
    tick(); chk("a_idle", {busy, done}, 2'b00);
    // hold freezes count, match keeps tracking
    push(9'h1FF, 1'b0);
    start = 1'b1; load_val = 9'h1F0;
    tick();
    start = 1'b0; hold = 1'b1;
    tick(); chk("b_load_ignores_hold", count, 9'h1F0);
    cmp_a = 4'd3; cmp_b = 4'd3;
    tick(); chk("b_hold1", {match, count}, {1'b1, 9'h1F0});
    cmp_b = 4'd4;
    tick(); chk("b_hold2", {match, count}, {1'b0, 9'h1F0});
    tick(); tick(); tick();
    chk("b_hold5", {busy, count}, {1'b1, 9'h1F0});
    hold = 1'b0;
    tick(); chk("b_resume", count, 9'h1F1);
    wait_done(40, "b_wait_done");
    tick(); chk("b_idle", {busy, count}, {1'b0, 9'h1FF});
    // start held through a whole run: no re-entry until after an IDLE cycle
    push(9'h1FF, 1'b0);
    push(9'h1FF, 1'b0);
    start = 1'b1; load_val = 9'h1FE;
    tick(); tick(); chk("c_c0", count, 9'h1FE);
    tick(); tick(); chk("c_done1", done, 1);
    tick(); chk("c_idle_gap", busy, 0);
    tick(); chk("c_reload", {busy, count}, {1'b1, 9'h1FF});
    tick(); chk("c_c0b", count, 9'h1FE);
    start = 1'b0;
    tick(); tick(); chk("c_done2", done, 1);
    tick();
    // reset mid-run
    start = 1'b1; load_val = 9'h100;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("d_mid", count, 9'h105);
    hold = 1'b1; cmp_a = 4'd7; cmp_b = 4'd7;
    tick(); chk("d_match_pre", {match, count}, {1'b1, 9'h105});
    rst_n = 1'b0; start = 1'b1;
    tick();
    chk("d_rst", {count, busy, done, match}, {9'h000, 3'b000});
    rst_n = 1'b1; start = 1'b0; hold = 1'b0; cmp_b = 4'd2;
    tick(); chk("d_idle", busy, 0);
    // all-ones load finishes three edges after start
    push(9'h1FF, 1'b0);
    start = 1'b1; load_val = 9'h1FF;
    tick();
    start = 1'b0;
    tick(); chk("e_run", {done, tc, count}, {2'b01, 9'h1FF});
    tick(); chk("e_done3", {done, tc, count}, {2'b11, 9'h1FF});
    tick();
    // compare equal from RUN cycle 3
`ifdef LAL_SEQ_CTRL_MATCH_STOP_EN
    push(9'h012, 1'b1);
`else
    push(9'h1FF, 1'b1);
`endif
    start = 1'b1; load_val = 9'h010; cmp_a = 4'd1; cmp_b = 4'd2;
    tick();
    start = 1'b0;
    tick(); chk("f_c1", count, 9'h010);
    tick(); chk("f_c2", count, 9'h011);
    tick(); chk("f_c3", count, 9'h012);
    cmp_a = 4'd5; cmp_b = 4'd5;
    wait_done(600, "f_wait_done");
    tick(); tick();
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
